// File: rtl/display_refresh_ctrl_pkg.sv
// Shared types and constants for the 7-segment refresh sequencer.
// Holds the FSM encoding, the default blank code and the blink field bit positions.
package display_refresh_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

  // Bit positions inside the one-hot blink field select
  localparam logic [1:0] FLD_HOURS   = 2'd2;
  localparam logic [1:0] FLD_MINUTES = 2'd1;
  localparam logic [1:0] FLD_SECONDS = 2'd0;

  function automatic logic [3:0] blank_digit(input logic [3:0] digit,
                                             input logic       blank,
                                             input logic [3:0] code);
    return blank ? code : digit;
  endfunction

endpackage

// File: rtl/sysclk_divider.sv
// Free-running divider: counts 0..DIV-1 and emits a registered one-cycle tick on wrap.
// Shared by the refresh-rate and blink-rate timebases.
module sysclk_divider #(
  parameter int unsigned DIV = 500_000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (cnt == LAST);
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_refresh_ctrl.sv
// Frame sequencer for the serial 7-segment path: snapshots the clock digits,
// applies blink blanking and colon blink, then runs the start/busy handshake.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | waiting for a pending request with the output path free
//   ST_LOAD      | one cycle: capture digits, blanking, dps and enable
//   ST_START     | one cycle: start strobe, arm the ack timeout
//   ST_WAIT_ACK  | waiting for busy to rise; timeout sets the sticky error
//   ST_WAIT_DONE | waiting for busy to fall; pulses frame_done
module display_refresh_ctrl
  import display_refresh_ctrl_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ  = 50_000_000,
  parameter int unsigned REFRESH_HZ  = 100,
  parameter int unsigned BLINK_HZ    = 2,
  parameter logic [3:0]  BLANK_CODE  = BLANK_CODE_DEF,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_update_stb,
  input  logic [2:0] i_blink_sel,
  input  logic       i_colon_en,
  input  logic [3:0] i_hours_msb,
  input  logic [3:0] i_hours_lsb,
  input  logic [3:0] i_minutes_msb,
  input  logic [3:0] i_minutes_lsb,
  input  logic [3:0] i_seconds_msb,
  input  logic [3:0] i_seconds_lsb,
  input  logic       i_busy,
  output logic       o_start_stb,
  output logic       o_en,
  output logic [3:0] o_hours_msb,
  output logic [3:0] o_hours_lsb,
  output logic [3:0] o_minutes_msb,
  output logic [3:0] o_minutes_lsb,
  output logic [3:0] o_seconds_msb,
  output logic [3:0] o_seconds_lsb,
  output logic       o_dp_hours1,
  output logic       o_dp_hours2,
  output logic       o_dp_minutes1,
  output logic       o_dp_minutes2,
  output logic       o_dp_seconds1,
  output logic       o_dp_seconds2,
  output logic       o_frame_done,
  output logic       o_error
);

  localparam int unsigned REFRESH_DIV = SYS_CLK_HZ / REFRESH_HZ;
  localparam int unsigned BLINK_DIV   = SYS_CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned TO_W        = $clog2(ACK_TIMEOUT + 1);

  state_t          state, state_nxt;
  logic            refresh_tick, blink_tick;
  logic            blink_phase;
  logic            pending;
  logic            load_go;
  logic            err_set;
  logic [TO_W-1:0] to_cnt;
  logic            blank_h, blank_m, blank_s;

  sysclk_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (refresh_tick)
  );

  sysclk_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (blink_tick)
  );

  assign load_go = (state == ST_IDLE) && (state_nxt == ST_LOAD);

  // A request arriving in the same cycle as the LOAD entry survives for the next frame
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pending     <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      pending     <= refresh_tick | blink_tick | i_update_stb | (pending & ~load_go);
      blink_phase <= blink_phase ^ blink_tick;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_start_stb  = 1'b0;
    o_frame_done = 1'b0;
    err_set      = 1'b0;
    case (state)
      ST_IDLE:      if (pending && !i_busy) state_nxt = ST_LOAD;
      ST_LOAD:      state_nxt = ST_START;
      ST_START: begin
        o_start_stb = 1'b1;
        state_nxt   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (i_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (to_cnt <= TO_W'(1)) begin
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_busy) begin
          o_frame_done = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Down-counter gives busy ACK_TIMEOUT full WAIT_ACK cycles to rise
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      to_cnt  <= '0;
      o_error <= 1'b0;
    end else begin
      if (state == ST_START)                        to_cnt <= TO_W'(ACK_TIMEOUT);
      else if (state == ST_WAIT_ACK && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
      if (err_set) o_error <= 1'b1;
    end
  end

  assign blank_h = blink_phase & i_blink_sel[FLD_HOURS];
  assign blank_m = blink_phase & i_blink_sel[FLD_MINUTES];
  assign blank_s = blink_phase & i_blink_sel[FLD_SECONDS];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_en          <= 1'b0;
      o_hours_msb   <= '0;
      o_hours_lsb   <= '0;
      o_minutes_msb <= '0;
      o_minutes_lsb <= '0;
      o_seconds_msb <= '0;
      o_seconds_lsb <= '0;
      o_dp_hours1   <= 1'b0;
      o_dp_hours2   <= 1'b0;
      o_dp_minutes1 <= 1'b0;
      o_dp_minutes2 <= 1'b0;
      o_dp_seconds1 <= 1'b0;
      o_dp_seconds2 <= 1'b0;
    end else if (state == ST_LOAD) begin
      o_en          <= i_en;
      o_hours_msb   <= blank_digit(i_hours_msb,   blank_h, BLANK_CODE);
      o_hours_lsb   <= blank_digit(i_hours_lsb,   blank_h, BLANK_CODE);
      o_minutes_msb <= blank_digit(i_minutes_msb, blank_m, BLANK_CODE);
      o_minutes_lsb <= blank_digit(i_minutes_lsb, blank_m, BLANK_CODE);
      o_seconds_msb <= blank_digit(i_seconds_msb, blank_s, BLANK_CODE);
      o_seconds_lsb <= blank_digit(i_seconds_lsb, blank_s, BLANK_CODE);
      o_dp_hours1   <= 1'b0;
      o_dp_hours2   <= i_colon_en & ~blink_phase;
      o_dp_minutes1 <= 1'b0;
      o_dp_minutes2 <= i_colon_en & ~blink_phase;
      o_dp_seconds1 <= 1'b0;
      o_dp_seconds2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Self-checking bench for display_refresh_ctrl: directed timing sequences, a blink/colon
// vector table and a randomized run against a request-timestamp reference model.
module tb_display_refresh_ctrl;

  localparam int REF_DIV = 100;
  localparam int BLK_DIV = 250;
  localparam int ACK_TO  = 15;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b1;
  logic       i_en = 1'b0, i_update_stb = 1'b0, i_colon_en = 1'b0, i_busy = 1'b0;
  logic [2:0] i_blink_sel = '0;
  logic [3:0] i_hours_msb = '0, i_hours_lsb = '0, i_minutes_msb = '0;
  logic [3:0] i_minutes_lsb = '0, i_seconds_msb = '0, i_seconds_lsb = '0;
  logic       o_start_stb, o_en, o_frame_done, o_error;
  logic [3:0] o_hours_msb, o_hours_lsb, o_minutes_msb, o_minutes_lsb, o_seconds_msb, o_seconds_lsb;
  logic       o_dp_hours1, o_dp_hours2, o_dp_minutes1, o_dp_minutes2, o_dp_seconds1, o_dp_seconds2;

  always #5 i_clk = ~i_clk;

  display_refresh_ctrl #(
    .SYS_CLK_HZ(10_000), .REFRESH_HZ(100), .BLINK_HZ(20), .BLANK_CODE(4'hF), .ACK_TIMEOUT(15)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_update_stb(i_update_stb),
    .i_blink_sel(i_blink_sel), .i_colon_en(i_colon_en),
    .i_hours_msb(i_hours_msb), .i_hours_lsb(i_hours_lsb),
    .i_minutes_msb(i_minutes_msb), .i_minutes_lsb(i_minutes_lsb),
    .i_seconds_msb(i_seconds_msb), .i_seconds_lsb(i_seconds_lsb),
    .i_busy(i_busy), .o_start_stb(o_start_stb), .o_en(o_en),
    .o_hours_msb(o_hours_msb), .o_hours_lsb(o_hours_lsb),
    .o_minutes_msb(o_minutes_msb), .o_minutes_lsb(o_minutes_lsb),
    .o_seconds_msb(o_seconds_msb), .o_seconds_lsb(o_seconds_lsb),
    .o_dp_hours1(o_dp_hours1), .o_dp_hours2(o_dp_hours2),
    .o_dp_minutes1(o_dp_minutes1), .o_dp_minutes2(o_dp_minutes2),
    .o_dp_seconds1(o_dp_seconds1), .o_dp_seconds2(o_dp_seconds2),
    .o_frame_done(o_frame_done), .o_error(o_error)
  );

  // {en, six digits, dps h1 h2 m1 m2 s1 s2}
  logic [30:0] act_frame;
  logic [33:0] act_all;
  assign act_frame = {o_en, o_hours_msb, o_hours_lsb, o_minutes_msb, o_minutes_lsb,
                      o_seconds_msb, o_seconds_lsb, o_dp_hours1, o_dp_hours2,
                      o_dp_minutes1, o_dp_minutes2, o_dp_seconds1, o_dp_seconds2};
  assign act_all   = {o_start_stb, o_frame_done, o_error, act_frame};

  int tests = 0, fails = 0;
  int cyc = 0;

  logic        nx_stb = 1'b0, nx_en = 1'b0, nx_colon = 1'b0;
  logic [2:0]  nx_sel = '0;
  logic [23:0] nx_dig = '0;
  bit          ack_en = 1'b1;
  int          cur_dur = 20;

  int          req_q[$];
  int          m_idle_from, m_load, m_start, m_done, m_err_from, busy_from, busy_to;
  logic [30:0] m_frame, m_frame_next;
  int          obs_first_start, obs_last_start, obs_start_cnt, obs_first_done, obs_first_err;

  typedef struct {
    logic [2:0]  sel;
    logic        colon;
    logic        en;
    logic        ph;
    logic [30:0] exp_frame;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Blink phase seen by a LOAD in cycle l: toggles take effect the cycle after each tick
  function automatic logic phase_at(input int l);
    return (((l - 1) / BLK_DIV) % 2) != 0;
  endfunction

  function automatic logic [30:0] frame_of(input logic en, input logic [23:0] d,
                                           input logic [2:0] sel, input logic colon,
                                           input logic ph);
    logic [23:0] q;
    logic        dp;
    q = d;
    if (ph && sel[2]) q[23:16] = 8'hFF;
    if (ph && sel[1]) q[15:8]  = 8'hFF;
    if (ph && sel[0]) q[7:0]   = 8'hFF;
    dp = colon & ~ph;
    return {en, q, 1'b0, dp, 1'b0, dp, 1'b0, 1'b0};
  endfunction

  task automatic model_reset();
    req_q.delete();
    m_idle_from = 0;  m_load = -10; m_start = -10; m_done = -10;
    m_err_from = 1 << 30; busy_from = -10; busy_to = -20;
    m_frame = '0; m_frame_next = '0;
    obs_first_start = -1; obs_last_start = -1; obs_start_cnt = 0;
    obs_first_done = -1; obs_first_err = -1;
  endtask

  task automatic step();
    @(posedge i_clk);
    cyc++;
    #1;
    i_update_stb = nx_stb;
    nx_stb       = 1'b0;
    i_en         = nx_en;
    i_blink_sel  = nx_sel;
    i_colon_en   = nx_colon;
    {i_hours_msb, i_hours_lsb, i_minutes_msb, i_minutes_lsb, i_seconds_msb, i_seconds_lsb} = nx_dig;
    i_busy = (cyc >= busy_from) && (cyc <= busy_to);
    if (i_update_stb || (cyc % REF_DIV == 0) || (cyc % BLK_DIV == 0)) req_q.push_back(cyc);
    // A request seen in cycle r is pending from r+1; frame starts two cycles after the idle decision
    if (cyc >= m_idle_from && req_q.size() > 0 && req_q[0] < cyc && !i_busy) begin
      m_load  = cyc + 1;
      m_start = cyc + 2;
      while (req_q.size() > 0 && req_q[0] <= cyc - 1) void'(req_q.pop_front());
      if (ack_en) begin
        busy_from   = m_start + 1;
        busy_to     = m_start + cur_dur;
        m_done      = m_start + cur_dur + 1;
        m_idle_from = m_done + 1;
      end else begin
        m_done = -10;
        if (m_err_from > m_start + ACK_TO + 1) m_err_from = m_start + ACK_TO + 1;
        m_idle_from = m_start + ACK_TO + 1;
      end
    end
    if (cyc == m_load)
      m_frame_next = frame_of(i_en, nx_dig, i_blink_sel, i_colon_en, phase_at(cyc));
    if (cyc == m_start) m_frame = m_frame_next;
    #1;
    if (o_start_stb) begin
      obs_start_cnt++;
      obs_last_start = cyc;
      if (obs_first_start < 0) obs_first_start = cyc;
    end
    if (o_frame_done && obs_first_done < 0) obs_first_done = cyc;
    if (o_error && obs_first_err < 0) obs_first_err = cyc;
    chk("start_stb",  64'(o_start_stb),  64'(cyc == m_start));
    chk("frame_done", 64'(o_frame_done), 64'(cyc == m_done));
    chk("error",      64'(o_error),      64'(cyc >= m_err_from));
    chk("frame_regs", 64'(act_frame),    64'(m_frame));
  endtask

  task automatic do_reset();
    #2 i_reset_n = 1'b0;
    i_update_stb = 1'b0;
    i_busy       = 1'b0;
    #1 chk("reset_outputs", 64'(act_all), 64'(0));
    @(posedge i_clk);
    #1 chk("reset_held", 64'(act_all), 64'(0));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  initial begin
    int   cnt0, hold_bad, found;
    logic [30:0] snap;

    vt[0] = '{3'b010, 1'b1, 1'b1, 1'b0, {1'b1, 24'h125937, 6'b010100}};
    vt[1] = '{3'b010, 1'b1, 1'b1, 1'b1, {1'b1, 24'h12FF37, 6'b000000}};
    vt[2] = '{3'b100, 1'b0, 1'b1, 1'b1, {1'b1, 24'hFF5937, 6'b000000}};
    vt[3] = '{3'b001, 1'b1, 1'b1, 1'b1, {1'b1, 24'h1259FF, 6'b000000}};
    vt[4] = '{3'b101, 1'b1, 1'b0, 1'b0, {1'b0, 24'h125937, 6'b010100}};
    vt[5] = '{3'b111, 1'b0, 1'b1, 1'b1, {1'b1, 24'hFFFFFF, 6'b000000}};
    vt[6] = '{3'b000, 1'b1, 1'b1, 1'b1, {1'b1, 24'h125937, 6'b000000}};

    #1 i_reset_n = 1'b0;
    #2 chk("por_outputs", 64'(act_all), 64'(0));
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc = 0;
    model_reset();

    // First periodic refresh after reset
    ack_en = 1; cur_dur = 20;
    repeat (130) step();
    chk("t1_first_start_cyc", 64'(obs_first_start), 64'(103));
    chk("t1_first_done_cyc",  64'(obs_first_done),  64'(124));

    // Update strobe at cycle 10, busy for 48 cycles, live digits change mid-frame
    do_reset();
    nx_dig = 24'h123456; nx_en = 1'b1; cur_dur = 48;
    while (cyc < 9) step();
    nx_stb = 1'b1;
    hold_bad = 0;
    snap = '0;
    while (cyc < 64) begin
      step();
      if (cyc == 13) snap = act_frame;
      if (cyc >= 14 && cyc <= 61 && act_frame !== snap) hold_bad++;
      if (cyc == 30) nx_dig = 24'h987654;
    end
    chk("t2_start_cyc", 64'(obs_first_start), 64'(13));
    chk("t2_done_cyc",  64'(obs_first_done),  64'(62));
    chk("t2_digits_hold_while_busy", 64'(hold_bad), 64'(0));

    // Two strobes and a refresh tick during busy coalesce into one frame
    cur_dur = 40;
    while (cyc < 69) step();
    nx_stb = 1'b1;
    while (cyc < 113) begin
      step();
      if (cyc == 79 || cyc == 89) nx_stb = 1'b1;
    end
    cnt0 = obs_start_cnt;
    cur_dur = 10;
    while (cyc < 199) step();
    chk("t3_coalesced_start_count", 64'(obs_start_cnt - cnt0), 64'(1));
    chk("t3_coalesced_start_cyc",   64'(obs_last_start),       64'(117));

    // Blink/colon vector table
    nx_dig = 24'h125937; cur_dur = 5;
    for (int i = 0; i < 7; i++) begin
      nx_sel = vt[i].sel; nx_colon = vt[i].colon; nx_en = vt[i].en;
      repeat (3) step();
      found = 0;
      for (int k = 0; k < 1000 && found == 0; k++) begin
        step();
        if (o_start_stb && phase_at(cyc - 1) == vt[i].ph) begin
          found = 1;
          chk($sformatf("t4_vec%0d_frame", i), 64'(act_frame), 64'(vt[i].exp_frame));
        end
      end
      chk($sformatf("t4_vec%0d_start_seen", i), 64'(found), 64'(1));
    end

    // Busy never rises: sticky error, FSM keeps refreshing
    do_reset();
    ack_en = 0;
    while (cyc < 9) step();
    nx_stb = 1'b1;
    while (cyc < 110) step();
    chk("t5_error_cyc",         64'(obs_first_err),  64'(29));
    chk("t5_refresh_after_err", 64'(obs_last_start), 64'(103));

    // Asynchronous reset in the middle of WAIT_DONE
    do_reset();
    ack_en = 1; cur_dur = 30; nx_en = 1'b1;
    while (cyc < 9) step();
    nx_stb = 1'b1;
    while (cyc < 20) step();
    chk("t6_en_before_reset", 64'(o_en),   64'(1));
    chk("t6_busy_mid_frame",  64'(i_busy), 64'(1));
    do_reset();

    // Randomized traffic against the reference model
    ack_en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) nx_stb = 1'b1;
      if ($urandom_range(9) == 0)  nx_dig = 24'($urandom());
      if ($urandom_range(15) == 0) nx_sel = 3'($urandom_range(7));
      if ($urandom_range(15) == 0) nx_colon = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) nx_en = 1'($urandom_range(1));
      cur_dur = int'($urandom_range(40, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
